// File: rtl/pic_wr_ctrl.sv
// Picture RAM write controller: turns a UART byte stream into sequential RAM writes
// for one frame. Optional `PIC_HDR_EN requires a 0xAA header byte before each frame.
module pic_wr_ctrl #(
  parameter int PIC_SIZE    = 10000,
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pi_flag,
  input  logic [7:0]        pi_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              pic_valid,
  output logic              busy,
  output logic              err_timeout,
  output logic [1:0]        dbg_state
);

  // Handshake: pi_flag is a valid-only strobe (the block always accepts, no ready),
  // and wr_en is a valid-only strobe toward the RAM; wr_addr/wr_data qualify it.

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_SIZE - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
`ifdef PIC_HDR_EN
  localparam logic [7:0] HDR_BYTE = 8'hAA;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              wr_en_n, frame_done_n, pic_valid_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n;
  logic              do_wr, timeout;
  logic [ADDR_W-1:0] tgt_addr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      cnt        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      pic_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      cnt        <= cnt_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      frame_done <= frame_done_n;
      pic_valid  <= pic_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    addr_n       = addr;
    cnt_n        = '0;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    frame_done_n = 1'b0;
    pic_valid_n  = pic_valid;
    do_wr        = 1'b0;
    timeout      = 1'b0;
    tgt_addr     = addr;

    case (state)
      IDLE, DONE: begin
        if (pi_flag) begin
`ifdef PIC_HDR_EN
          if (pi_data == HDR_BYTE) begin
            state_n     = LOAD;
            addr_n      = '0;
            pic_valid_n = 1'b0;
          end
`else
          do_wr    = 1'b1;
          tgt_addr = '0;
`endif
        end
      end
      LOAD: begin
        // A byte arriving in the expiry cycle wins over the timeout.
        if (pi_flag) begin
          do_wr    = 1'b1;
          tgt_addr = addr;
        end else if (cnt == CNT_LAST) begin
          timeout     = 1'b1;
          addr_n      = '0;
          pic_valid_n = 1'b0;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        addr_n  = '0;
      end
    endcase

    if (do_wr) begin
      wr_en_n     = 1'b1;
      wr_addr_n   = tgt_addr;
      wr_data_n   = pi_data;
      pic_valid_n = 1'b0;
      // Last pixel closes the frame; the address never runs past LAST_ADDR.
      if (tgt_addr == LAST_ADDR) begin
        frame_done_n = 1'b1;
        pic_valid_n  = 1'b1;
        addr_n       = '0;
        state_n      = DONE;
      end else begin
        addr_n  = tgt_addr + 1'b1;
        state_n = LOAD;
      end
    end
  end

  assign busy        = (state == LOAD);
  assign err_timeout = timeout;
  assign dbg_state   = state;

endmodule

// File: tb/tb_pic_wr_ctrl.sv
// Directed bench for pic_wr_ctrl (PIC_SIZE=4, TIMEOUT_CYC=16); define PIC_HDR_EN
// to run the header-mode sequence instead of the default-build sequence.
module tb_pic_wr_ctrl;
  localparam int PIC_SIZE    = 4;
  localparam int ADDR_W      = 2;
  localparam int TIMEOUT_CYC = 16;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              pi_flag   = 1'b0;
  logic [7:0]        pi_data   = 8'h00;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_done;
  logic              pic_valid;
  logic              busy;
  logic              err_timeout;
  logic [1:0]        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset
  always #5 sys_clk = ~sys_clk;

  pic_wr_ctrl #(
    .PIC_SIZE    (PIC_SIZE),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pi_flag     (pi_flag),
    .pi_data     (pi_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .pic_valid   (pic_valid),
    .busy        (busy),
    .err_timeout (err_timeout),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One byte pulse, then check the registered write it produces.
  task automatic send_wr(input logic [7:0] d, input int a, input logic fd,
                         input logic pv, input logic bz);
    pi_flag = 1'b1;
    pi_data = d;
    tick();
    pi_flag = 1'b0;
    check("wr_en",      32'(wr_en), 32'd1);
    check("wr_addr",    32'(wr_addr), 32'(a));
    check("wr_data",    32'(wr_data), 32'(d));
    check("frame_done", 32'(frame_done), 32'(fd));
    check("pic_valid",  32'(pic_valid), 32'(pv));
    check("busy",       32'(busy), 32'(bz));
  endtask

  // Idle cycles: no write and no timeout expected in any of them.
  task automatic quiet(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (wr_en !== 1'b0 || err_timeout !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

`ifdef PIC_HDR_EN
  task automatic send_nowr(input logic [7:0] d, input logic bz);
    pi_flag = 1'b1;
    pi_data = d;
    tick();
    pi_flag = 1'b0;
    check("hdr_no_wr", 32'(wr_en), 32'd0);
    check("hdr_busy",  32'(busy), 32'(bz));
  endtask
`endif

  initial begin
    int bad;
    logic [7:0] frame1 [4];
    frame1[0] = 8'h11; frame1[1] = 8'h22; frame1[2] = 8'h33; frame1[3] = 8'h44;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_wr_en",   32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_pv",      32'(pic_valid), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_state",   32'(dbg_state), 32'd0);
    sys_rst_n = 1'b1;
    tick();

`ifdef PIC_HDR_EN
    send_nowr(8'h12, 1'b0);
    check("hdr_ign_state", 32'(dbg_state), 32'd0);
    send_nowr(8'hAA, 1'b1);
    check("hdr_start_pv", 32'(pic_valid), 32'd0);
    send_wr(8'hAA, 0, 1'b0, 1'b0, 1'b1);
    send_wr(8'h01, 1, 1'b0, 1'b0, 1'b1);
    send_wr(8'h02, 2, 1'b0, 1'b0, 1'b1);
    send_wr(8'h03, 3, 1'b1, 1'b1, 1'b0);
    check("hdr_done_state", 32'(dbg_state), 32'd2);
    // In DONE, a non-header byte is ignored and the frame stays valid.
    send_nowr(8'h55, 1'b0);
    check("hdr_done_pv", 32'(pic_valid), 32'd1);
`else
    // Full frame, pulses 10 cycles apart
    for (int i = 0; i < 4; i++) begin
      send_wr(frame1[i], i, (i == 3), (i == 3), (i != 3));
      if (i != 3) quiet("gap_quiet", 9);
    end
    tick();
    check("fd_pulse_end", 32'(frame_done), 32'd0);
    check("pv_hold",      32'(pic_valid), 32'd1);
    check("done_state",   32'(dbg_state), 32'd2);
    quiet("done_no_timeout", 24);

    // New frame drops pic_valid on its first write
    send_wr(8'h55, 0, 1'b0, 1'b0, 1'b1);
    send_wr(8'h66, 1, 1'b0, 1'b0, 1'b1);

    // Timeout 15 cycles after the last write cycle
    bad = 0;
    for (int k = 1; k < 15; k++) begin
      tick();
      if (err_timeout !== 1'b0 || wr_en !== 1'b0) bad++;
    end
    check("to_early", 32'(bad), 32'd0);
    tick();
    check("to_pulse",      32'(err_timeout), 32'd1);
    check("to_busy",       32'(busy), 32'd1);
    tick();
    check("to_pulse_end",  32'(err_timeout), 32'd0);
    check("to_idle_state", 32'(dbg_state), 32'd0);
    check("to_idle_busy",  32'(busy), 32'd0);
    check("to_pv",         32'(pic_valid), 32'd0);
    check("to_no_wr",      32'(wr_en), 32'd0);
    quiet("idle_no_timeout", 20);
    send_wr(8'h77, 0, 1'b0, 1'b0, 1'b1);

    // Byte in the expiry cycle wins over the timeout
    repeat (15) tick();
    check("race_pre", 32'(err_timeout), 32'd1);
    pi_flag = 1'b1;
    pi_data = 8'h88;
    #1;
    check("race_no_err", 32'(err_timeout), 32'd0);
    tick();
    pi_flag = 1'b0;
    check("race_wr_en",   32'(wr_en), 32'd1);
    check("race_wr_addr", 32'(wr_addr), 32'd1);
    check("race_wr_data", 32'(wr_data), 32'h88);
    check("race_busy",    32'(busy), 32'd1);
    quiet("race_after", 10);

    // Asynchronous reset mid-frame
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_wr_en",   32'(wr_en), 32'd0);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    check("arst_wr_data", 32'(wr_data), 32'd0);
    check("arst_fd",      32'(frame_done), 32'd0);
    check("arst_pv",      32'(pic_valid), 32'd0);
    check("arst_busy",    32'(busy), 32'd0);
    check("arst_err",     32'(err_timeout), 32'd0);
    check("arst_state",   32'(dbg_state), 32'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    send_wr(8'hA1, 0, 1'b0, 1'b0, 1'b1);
    send_wr(8'hA2, 1, 1'b0, 1'b0, 1'b1);
    send_wr(8'hA3, 2, 1'b0, 1'b0, 1'b1);
    send_wr(8'hA4, 3, 1'b1, 1'b1, 1'b0);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
